// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit that owns the HI/LO registers.
// One bit per clock over a shared 2*WIDTH accumulator, with a start/busy/done handshake.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] gr1,
  input  logic [WIDTH-1:0] gr2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] LAST_IT = 6'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_r;
  logic [5:0]           cnt_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     opnd_r;
  logic                 is_div_r, neg_q_r, neg_r_r;
  logic [WIDTH-1:0]     hi_r, lo_r;
  logic                 busy_r, done_r, dbz_r;

  logic                 op_mul_s, op_div_s, op_signed_s, op_mthi_s, op_mtlo_s, op_valid_s;
  logic                 a_neg_s, b_neg_s;
  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic [WIDTH:0]       shift_s, mul_sum_s;
  logic                 rem_ge_s;
  logic [WIDTH-1:0]     rem_diff_s;
  logic [2*WIDTH-1:0]   acc_next_s, prod_s;
  logic [WIDTH-1:0]     fix_hi_s, fix_lo_s;

  // Decode funct field and form operand magnitudes for signed ops
  always_comb begin
    op_mul_s    = 1'b0;
    op_div_s    = 1'b0;
    op_signed_s = 1'b0;
    op_mthi_s   = 1'b0;
    op_mtlo_s   = 1'b0;
    case (func)
      F_MULT:  begin op_mul_s = 1'b1; op_signed_s = 1'b1; end
      F_MULTU: op_mul_s = 1'b1;
      F_DIV:   begin op_div_s = 1'b1; op_signed_s = 1'b1; end
      F_DIVU:  op_div_s = 1'b1;
      F_MTHI:  op_mthi_s = 1'b1;
      F_MTLO:  op_mtlo_s = 1'b1;
      default: op_mul_s = 1'b0;
    endcase
    op_valid_s = op_mul_s | op_div_s | op_mthi_s | op_mtlo_s;
    a_neg_s    = op_signed_s & gr1[WIDTH-1];
    b_neg_s    = op_signed_s & gr2[WIDTH-1];
    a_mag_s    = a_neg_s ? ({WIDTH{1'b0}} - gr1) : gr1;
    b_mag_s    = b_neg_s ? ({WIDTH{1'b0}} - gr2) : gr2;
  end

  // One iteration: acc holds {partial, multiplier} for mult and {remainder, quotient} for div
  always_comb begin
    shift_s    = acc_r[2*WIDTH-1:WIDTH-1];
    rem_ge_s   = shift_s >= {1'b0, opnd_r};
    rem_diff_s = shift_s[WIDTH-1:0] - opnd_r;
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    if (is_div_r) begin
      if (rem_ge_s) begin
        acc_next_s = {rem_diff_s, acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_s = {shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction applied when leaving RUN
  always_comb begin
    prod_s = neg_q_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
    if (is_div_r) begin
      fix_lo_s = neg_q_r ? ({WIDTH{1'b0}} - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
      fix_hi_s = neg_r_r ? ({WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
    end else begin
      fix_lo_s = prod_s[WIDTH-1:0];
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, operand latch, iteration and HI/LO update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= 6'd0;
      acc_r    <= {(2*WIDTH){1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start && op_valid_s) begin
            done_r <= 1'b1;
            if (op_div_s && (gr2 == {WIDTH{1'b0}})) begin
              dbz_r <= 1'b1;
            end else if (op_mthi_s) begin
              dbz_r <= 1'b0;
              hi_r  <= gr1;
            end else if (op_mtlo_s) begin
              dbz_r <= 1'b0;
              lo_r  <= gr1;
            end else begin
              // Arithmetic op: done comes from FIX instead
              done_r   <= 1'b0;
              dbz_r    <= 1'b0;
              busy_r   <= 1'b1;
              state_r  <= S_RUN;
              cnt_r    <= 6'd0;
              is_div_r <= op_div_s;
              neg_q_r  <= a_neg_s ^ b_neg_s;
              neg_r_r  <= a_neg_s;
              acc_r    <= {{WIDTH{1'b0}}, (op_div_s ? a_mag_s : b_mag_s)};
              opnd_r   <= op_div_s ? b_mag_s : a_mag_s;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == LAST_IT) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          cnt_r   <= 6'd0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic results, handshake timing,
// divide-by-zero, mthi/mtlo, ignored starts, and asynchronous reset mid-operation.
module tb_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  logic        clk, rst, start;
  logic [5:0]  func;
  logic [31:0] gr1, gr2;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int lat, bcnt;
  bit saw_done;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .gr1(gr1), .gr2(gr2),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Returns at the negedge where done is seen (start left low),
  // so the caller may launch the next op in the done cycle. lat counts edges from
  // the accepting edge to the edge that raised done; -1 on timeout.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int poke_k, output int lat_o, output int busy_o);
    start = 1'b1; func = f; gr1 = a; gr2 = b;
    lat_o = -1; busy_o = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; func = 6'h00; gr1 = $urandom; gr2 = $urandom;
      end
      if (k == poke_k) begin
        start = 1'b1; func = F_DIV; gr1 = 32'h0000_0064; gr2 = 32'h0000_0000;
      end else if (k == poke_k + 1) begin
        start = 1'b0;
      end
      if (busy) busy_o++;
      if (done) begin
        lat_o = k - 1;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; func = 6'h00; gr1 = 32'h0; gr2 = 32'h0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_hilo", {hi, lo}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // mult with an ignored div start pulsed while busy
    do_op(F_MULT, 32'h0000_0002, 32'hFFFF_FFFD, 10, lat, bcnt);
    check("mult_lat", 64'(lat), 64'd33);
    check("mult_busy", 64'(bcnt), 64'd33);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    check("mult_dbz", div_by_zero, 1'b0);

    // Launched in the done cycle of the previous op
    do_op(F_MULTU, 32'h0000_0002, 32'hFFFF_FFFD, 0, lat, bcnt);
    check("b2b_lat", 64'(lat), 64'd33);
    check("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFA);

    do_op(F_DIV, 32'h0000_00F8, 32'hFFFF_FFF6, 0, lat, bcnt);
    check("div1_hilo", {hi, lo}, 64'h0000_0008_FFFF_FFE8);
    check("div1_busy", 64'(bcnt), 64'd33);

    do_op(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, lat, bcnt);
    check("div2_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    do_op(F_DIVU, 32'h8000_0000, 32'h0000_0003, 0, lat, bcnt);
    check("divu_hilo", {hi, lo}, 64'h0000_0002_2AAA_AAAA);

    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcnt);
    check("divovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    check("divovf_dbz", div_by_zero, 1'b0);

    do_op(F_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 0, lat, bcnt);
    check("multnn_hilo", {hi, lo}, 64'h0000_0000_0000_0009);

    do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bcnt);
    check("multumax_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // Idle cycles: done is a single pulse, HI/LO hold
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("idle_done", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // Invalid funct is ignored
    start = 1'b1; func = 6'h20; gr1 = 32'h1111_1111; gr2 = 32'h2222_2222;
    @(negedge clk);
    start = 1'b0;
    check("inv_done", done, 1'b0);
    check("inv_busy", busy, 1'b0);
    @(negedge clk);
    check("inv_busy2", busy, 1'b0);
    check("inv_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    do_op(F_MTHI, 32'h1234_5678, 32'h0, 0, lat, bcnt);
    check("mthi_lat", 64'(lat), 64'd0);
    check("mthi_busy", 64'(bcnt), 64'd0);
    check("mthi_hilo", {hi, lo}, 64'h1234_5678_0000_0001);

    do_op(F_DIVU, 32'h0000_0055, 32'h0, 0, lat, bcnt);
    check("dbz_lat", 64'(lat), 64'd0);
    check("dbz_busy", 64'(bcnt), 64'd0);
    check("dbz_flag", div_by_zero, 1'b1);
    check("dbz_hilo", {hi, lo}, 64'h1234_5678_0000_0001);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("dbz_held", div_by_zero, 1'b1);

    do_op(F_MTLO, 32'hCAFE_F00D, 32'h0, 0, lat, bcnt);
    check("mtlo_dbz", div_by_zero, 1'b0);
    check("mtlo_hilo", {hi, lo}, 64'h1234_5678_CAFE_F00D);
    @(negedge clk);

    // Reset mid-operation
    start = 1'b1; func = F_MULT; gr1 = 32'h0000_0007; gr2 = 32'h0000_0009;
    saw_done = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 10) begin start = 1'b1; func = F_DIV; gr2 = 32'h0000_0001; end
      if (k == 11) start = 1'b0;
      if (done) saw_done = 1'b1;
      if (k == 15) check("rst_mid_busy", busy, 1'b1);
    end
    check("rst_mid_nodone", saw_done, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_dbz", div_by_zero, 1'b0);
    check("arst_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("post_rst_quiet", saw_done, 1'b0);
    check("post_rst_hilo", {hi, lo}, 64'h0);

    do_op(F_MULT, 32'hFFFF_FFF9, 32'h0000_0006, 0, lat, bcnt);
    check("after_rst_lat", 64'(lat), 64'd33);
    check("after_rst_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
